obi2axi_bridge: RTL
===================

// Module: obi2axi_bridge
// PURPOSE
//   Parametrised successor to the single-purpose core-to-AXI adapter. Converts one OBI port
//   (req/gnt/rvalid) into single-beat AXI4 transactions with up to MAX_OUTSTANDING in flight.
//   Returns read AND write completions to the core as one in-order rvalid stream.
//   Sits between a cv32e40p instr/data port and one crossbar slave port.
// PARAMETERS
//   ADDR_WIDTH       32  address width, OBI and AXI
//   DATA_WIDTH       32  data width; AXI size = log2(DATA_WIDTH/8)
//   ID_WIDTH         2   AXI ID width
//   AXI_ID           0   fixed ID on every AR/AW (single ID => per-channel in-order)
//   MAX_OUTSTANDING  4   max granted-but-not-completed requests, >=1, power of 2
// PORTS
//   clk_i        in   1     clock
//   rst_i        in   1     synchronous reset, active-high
//   req_i        in   1     OBI request; addr/we/be/wdata stable until gnt
//   gnt_o        out  1     OBI grant
//   addr_i       in   AW    byte address, passed unchanged to AXI
//   we_i         in   1     1 = write
//   be_i         in   DW/8  byte enables -> w_strb
//   wdata_i      in   DW    write data
//   rvalid_o     out  1     one-cycle completion pulse, read or write
//   rdata_o      out  DW    read data; 0 for write completions
//   err_o        out  1     valid with rvalid_o: resp[1] of R/B (SLVERR/DECERR)
//   aw_valid_o/aw_ready_i/aw_addr_o/aw_id_o   AXI AW (len 0, burst INCR, prot/cache 0)
//   w_valid_o/w_ready_i/w_data_o/w_strb_o/w_last_o  AXI W (w_last_o tied 1)
//   b_valid_i/b_ready_o/b_resp_i(2)           AXI B
//   ar_valid_o/ar_ready_i/ar_addr_o/ar_id_o   AXI AR (len 0, burst INCR)
//   r_valid_i/r_ready_o/r_data_i/r_resp_i(2)  AXI R (r_last ignored)
// BEHAVIOUR
// - Reset: gnt_o, rvalid_o, err_o, all *_valid_o = 0; rdata_o = 0; b/r_ready_o = 1;
//   counter, order FIFO, hold regs cleared. Reset mid-operation drops everything in flight;
//   late AXI responses after reset are the system's problem, not handled.
// - gnt_o = req_i & issue_empty & (cnt < MAX_OUTSTANDING); combinational.
// - Issue stage: one register loaded on req_i&gnt_o. Next cycle drives ar_valid_o (read),
//   or aw_valid_o and w_valid_o (write). AW and W handshake independently;
//   aw_done/w_done flags drop each valid after its own handshake.
//   Stage frees after AR done, or after both AW and W done.
//   Max issue rate: one request per 2 cycles.
// - Order FIFO, depth MAX_OUTSTANDING, 1 bit/entry (1 = write); push on grant.
//   Pointers wrap modulo depth. Never overflows: gated by cnt.
// - R/B hold regs, one entry each: r_ready_o = !r_hold_v, b_ready_o = !b_hold_v.
//   A handshake captures data/resp.
// - Completion: if FIFO head = read and r_hold_v, or head = write and b_hold_v:
//   - next-cycle rvalid_o = 1, rdata_o/err_o from that hold reg;
//   - pop head; clear hold reg.
//   Reordered R/B (different channels) stall in hold until their turn.
// - cnt: +1 on grant, -1 on completion; both in one cycle => unchanged.
// - Latency (ready AXI): read req@0, AR@1, R@k => rvalid@k+1;
//   write req@0, AW/W@1, B@k => rvalid@k+1.
// - rdata_o holds last value when rvalid_o=0; zero on write completion.
// TESTING
// - Read 0x8000_0000, ar_ready=1, R@3 data 0xDEADBEEF OKAY
//   -> gnt@0, ar_valid@1, rvalid@4 rdata=0xDEADBEEF err=0.
// - Write be=0x3, aw_ready delayed 3 cyc, w_ready immediate -> w_valid drops after 1 cyc;
//   aw_valid held 3 cyc; one rvalid after B.
// - MAX=4, 5 back-to-back reads, R withheld -> 4 gnts, 5th gnt_o=0 until 1st rvalid.
// - Write then read; R returns before B -> R parked (r_ready_o=0 after capture);
//   rvalid order: write completion first, then read.
// - B resp=2'b10 -> rvalid with err_o=1, rdata_o=0; following read OKAY -> err_o=0.
// - rst_i asserted with 3 in flight -> next cycle all valids 0, cnt 0, gnt_o=req_i.

Source files
------------

// File: rtl/obi2axi_if.sv
// obi2axi_if: OBI core port plus single-beat AXI4 master channels; slave = bridge view, master = core/fabric view
interface obi2axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic                    req_i;
  logic                    gnt_o;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic                    rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic                    err_o;
  logic                    aw_valid_o;
  logic                    aw_ready_i;
  logic [ADDR_WIDTH-1:0]   aw_addr_o;
  logic [ID_WIDTH-1:0]     aw_id_o;
  logic                    w_valid_o;
  logic                    w_ready_i;
  logic [DATA_WIDTH-1:0]   w_data_o;
  logic [DATA_WIDTH/8-1:0] w_strb_o;
  logic                    w_last_o;
  logic                    b_valid_i;
  logic                    b_ready_o;
  logic [1:0]              b_resp_i;
  logic                    ar_valid_o;
  logic                    ar_ready_i;
  logic [ADDR_WIDTH-1:0]   ar_addr_o;
  logic [ID_WIDTH-1:0]     ar_id_o;
  logic                    r_valid_i;
  logic                    r_ready_o;
  logic [DATA_WIDTH-1:0]   r_data_i;
  logic [1:0]              r_resp_i;
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
           ar_ready_i, r_valid_i, r_data_i, r_resp_i,
    output gnt_o, rvalid_o, rdata_o, err_o, aw_valid_o, aw_addr_o, aw_id_o, w_valid_o, w_data_o,
           w_strb_o, w_last_o, b_ready_o, ar_valid_o, ar_addr_o, ar_id_o, r_ready_o
  );
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
           ar_ready_i, r_valid_i, r_data_i, r_resp_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, aw_valid_o, aw_addr_o, aw_id_o, w_valid_o, w_data_o,
           w_strb_o, w_last_o, b_ready_o, ar_valid_o, ar_addr_o, ar_id_o, r_ready_o
  );
endinterface

// File: rtl/obi2axi_bridge.sv
// obi2axi_bridge: OBI (req/gnt/rvalid) to single-beat AXI4 with in-order completions; ports clk_i, rst_i, bus (obi2axi_if.slave)
module obi2axi_bridge #(
  parameter int                  ADDR_WIDTH      = 32,
  parameter int                  DATA_WIDTH      = 32,
  parameter int                  ID_WIDTH        = 2,
  parameter logic [ID_WIDTH-1:0] AXI_ID          = '0,
  parameter int                  MAX_OUTSTANDING = 4
) (
  input logic       clk_i,
  input logic       rst_i,
  obi2axi_if.slave  bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW = DATA_WIDTH / 8;
  logic                       iss_v_q, iss_v_d, iss_we_q, iss_we_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]      iss_addr_q, iss_addr_d;
  logic [BW-1:0]              iss_be_q, iss_be_d;
  logic [DATA_WIDTH-1:0]      iss_wdata_q, iss_wdata_d;
  logic [MAX_OUTSTANDING-1:0] ord_q, ord_d;
  logic [PW-1:0]              wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       r_hold_v_q, r_hold_v_d, r_hold_err_q, r_hold_err_d;
  logic                       b_hold_v_q, b_hold_v_d, b_hold_err_q, b_hold_err_d;
  logic [DATA_WIDTH-1:0]      r_hold_data_q, r_hold_data_d, rdata_q, rdata_d;
  logic                       rvalid_q, rvalid_d, err_q, err_d;
  logic                       grant, aw_v, w_v, ar_v, aw_hs, w_hs, ar_hs, r_hs, b_hs, iss_done, pop_r, pop_b, head;
  logic                       unused_ok;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    grant         = bus.req_i & !iss_v_q & (cnt_q < CW'(MAX_OUTSTANDING));
    ar_v          = iss_v_q & !iss_we_q;
    aw_v          = iss_v_q & iss_we_q & !aw_done_q;
    w_v           = iss_v_q & iss_we_q & !w_done_q;
    ar_hs         = ar_v & bus.ar_ready_i;
    aw_hs         = aw_v & bus.aw_ready_i;
    w_hs          = w_v & bus.w_ready_i;
    r_hs          = bus.r_valid_i & !r_hold_v_q;
    b_hs          = bus.b_valid_i & !b_hold_v_q;
    iss_done      = iss_we_q ? (aw_done_q | aw_hs) & (w_done_q | w_hs) : ar_hs;
    iss_v_d       = grant | (iss_v_q & !iss_done);
    iss_we_d      = grant ? bus.we_i : iss_we_q;
    iss_addr_d    = grant ? bus.addr_i : iss_addr_q;
    iss_be_d      = grant ? bus.be_i : iss_be_q;
    iss_wdata_d   = grant ? bus.wdata_i : iss_wdata_q;
    aw_done_d     = iss_v_q & !iss_done & (aw_done_q | aw_hs);
    w_done_d      = iss_v_q & !iss_done & (w_done_q | w_hs);
    ord_d         = ord_q;
    if (grant) ord_d[wp_q] = bus.we_i;
    head          = ord_q[rp_q];
    pop_r         = (cnt_q != '0) & !head & (r_hold_v_q | r_hs);
    pop_b         = (cnt_q != '0) & head & (b_hold_v_q | b_hs);
    r_hold_v_d    = (r_hold_v_q | r_hs) & !pop_r;
    b_hold_v_d    = (b_hold_v_q | b_hs) & !pop_b;
    r_hold_data_d = r_hs ? bus.r_data_i : r_hold_data_q;
    r_hold_err_d  = r_hs ? bus.r_resp_i[1] : r_hold_err_q;
    b_hold_err_d  = b_hs ? bus.b_resp_i[1] : b_hold_err_q;
    rvalid_d      = pop_r | pop_b;
    rdata_d       = pop_b ? '0 : pop_r ? (r_hold_v_q ? r_hold_data_q : bus.r_data_i) : rdata_q;
    err_d         = pop_b ? (b_hold_v_q ? b_hold_err_q : bus.b_resp_i[1]) :
                    pop_r ? (r_hold_v_q ? r_hold_err_q : bus.r_resp_i[1]) : err_q;
    cnt_d         = cnt_q + CW'(grant) - CW'(rvalid_d);
    wp_d          = grant ? nxt(wp_q) : wp_q;
    rp_d          = rvalid_d ? nxt(rp_q) : rp_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_v_q       <= 1'b0;
      iss_we_q      <= 1'b0;
      iss_addr_q    <= '0;
      iss_be_q      <= '0;
      iss_wdata_q   <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      ord_q         <= '0;
      wp_q          <= '0;
      rp_q          <= '0;
      cnt_q         <= '0;
      r_hold_v_q    <= 1'b0;
      r_hold_data_q <= '0;
      r_hold_err_q  <= 1'b0;
      b_hold_v_q    <= 1'b0;
      b_hold_err_q  <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      iss_v_q       <= iss_v_d;
      iss_we_q      <= iss_we_d;
      iss_addr_q    <= iss_addr_d;
      iss_be_q      <= iss_be_d;
      iss_wdata_q   <= iss_wdata_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      ord_q         <= ord_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      cnt_q         <= cnt_d;
      r_hold_v_q    <= r_hold_v_d;
      r_hold_data_q <= r_hold_data_d;
      r_hold_err_q  <= r_hold_err_d;
      b_hold_v_q    <= b_hold_v_d;
      b_hold_err_q  <= b_hold_err_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
    end
  end
  assign bus.gnt_o      = grant;
  assign bus.ar_valid_o = ar_v;
  assign bus.ar_addr_o  = iss_addr_q;
  assign bus.ar_id_o    = AXI_ID;
  assign bus.aw_valid_o = aw_v;
  assign bus.aw_addr_o  = iss_addr_q;
  assign bus.aw_id_o    = AXI_ID;
  assign bus.w_valid_o  = w_v;
  assign bus.w_data_o   = iss_wdata_q;
  assign bus.w_strb_o   = iss_be_q;
  assign bus.w_last_o   = 1'b1;
  assign bus.r_ready_o  = !r_hold_v_q;
  assign bus.b_ready_o  = !b_hold_v_q;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.err_o      = err_q;
  assign unused_ok      = bus.r_resp_i[0] ^ bus.b_resp_i[0];
endmodule
